input_wrapper: RTL

INPUT_WRAPPER -- requirements
Module: input_wrapper

---
 rtl/input_wrapper_pkg.sv | 40 ++++
 rtl/input_classifier.sv | 71 +++++++
 rtl/input_wrapper.sv | 117 +++++++++++
 3 files changed

// File: rtl/input_wrapper_pkg.sv
// -----------------------------------------------------------------------------
// input_wrapper_pkg
// Definitions shared by the sqrt input and output wrappers: default operand
// geometry, operand class codes and the special-value mantissa/exponent
// constants (quiet NaN, signalling NaN, infinity, zero).
// -----------------------------------------------------------------------------
package input_wrapper_pkg;

  // Default IEEE-754 binary64 geometry. The mantissa width counts the hidden bit.
  localparam int DEF_M_SIZE   = 53;
  localparam int DEF_EXP_SIZE = 11;
  localparam int DEF_FRAC_SIZE = DEF_M_SIZE - 1;

  // Operand class code carried alongside the unpacked operand.
  typedef enum logic [2:0] {
    FLAG_ZERO     = 3'b000,
    FLAG_DENORM   = 3'b001,
    FLAG_INF      = 3'b010,
    FLAG_NAN      = 3'b011,
    FLAG_NORMAL   = 3'b100,
    FLAG_SIGN_ERR = 3'b111
  } flag_e;

  // Special-value encodings at the default geometry, as {hidden, fraction}
  // for mantissas and as the biased exponent field for exponents.
  localparam logic [DEF_M_SIZE-1:0]   QNAN_MANT = {2'b11, {(DEF_M_SIZE-2){1'b0}}};
  localparam logic [DEF_M_SIZE-1:0]   SNAN_MANT = {2'b10, {(DEF_M_SIZE-3){1'b0}}, 1'b1};
  localparam logic [DEF_M_SIZE-1:0]   INF_MANT  = {DEF_M_SIZE{1'b0}};
  localparam logic [DEF_M_SIZE-1:0]   ZERO_MANT = {DEF_M_SIZE{1'b0}};
  localparam logic [DEF_EXP_SIZE-1:0] QNAN_EXP  = {DEF_EXP_SIZE{1'b1}};
  localparam logic [DEF_EXP_SIZE-1:0] SNAN_EXP  = {DEF_EXP_SIZE{1'b1}};
  localparam logic [DEF_EXP_SIZE-1:0] INF_EXP   = {DEF_EXP_SIZE{1'b1}};
  localparam logic [DEF_EXP_SIZE-1:0] ZERO_EXP  = {DEF_EXP_SIZE{1'b0}};

  // True for the class codes the wrappers are allowed to emit.
  function automatic logic flag_is_legal(input logic [2:0] code);
    return (code != 3'b101) && (code != 3'b110);
  endfunction

endpackage

// File: rtl/input_classifier.sv
// -----------------------------------------------------------------------------
// input_classifier
// Purely combinational: splits an IEEE-754 operand into sign/exponent/fraction
// and produces the class code plus the mantissa/exponent handed to the sqrt
// core. Negative non-zero, non-NaN operands have no real square root and are
// reported as FLAG_SIGN_ERR with zeroed payload.
//
// Ports
//   data    in   M_SIZE+EXP_SIZE  operand, {sign, exponent, fraction}
//   mantisa out  M_SIZE           {hidden bit, fraction}
//   exp     out  EXP_SIZE         biased exponent
//   flags   out  3                operand class code
// -----------------------------------------------------------------------------
module input_classifier
  import input_wrapper_pkg::*;
#(
  parameter int M_SIZE   = DEF_M_SIZE,
  parameter int EXP_SIZE = DEF_EXP_SIZE
) (
  input  logic [M_SIZE+EXP_SIZE-1:0] data,
  output logic [M_SIZE-1:0]          mantisa,
  output logic [EXP_SIZE-1:0]        exp,
  output logic [2:0]                 flags
);

  localparam int FRAC_SIZE = M_SIZE - 1;
  localparam int W         = M_SIZE + EXP_SIZE;

  logic                 sign;
  logic [EXP_SIZE-1:0]  exp_field;
  logic [FRAC_SIZE-1:0] frac_field;
  logic                 exp_zero;
  logic                 exp_ones;
  logic                 frac_zero;

  assign sign       = data[W-1];
  assign exp_field  = data[W-2 -: EXP_SIZE];
  assign frac_field = data[FRAC_SIZE-1:0];
  assign exp_zero   = (exp_field == '0);
  assign exp_ones   = (exp_field == '1);
  assign frac_zero  = (frac_field == '0);

  // Priority order matters: signed zero and NaN of either sign are classified
  // before the sign check so that only the "real" negatives become errors.
  always_comb begin
    mantisa = '0;
    exp     = '0;
    flags   = FLAG_ZERO;
    if (exp_zero && frac_zero) begin
      flags = FLAG_ZERO;
    end else if (exp_ones && !frac_zero) begin
      flags   = FLAG_NAN;
      mantisa = {1'b1, frac_field};
      exp     = '1;
    end else if (sign) begin
      flags = FLAG_SIGN_ERR;
    end else if (exp_zero) begin
      // Denormal: no hidden bit, exponent field stays at zero.
      flags   = FLAG_DENORM;
      mantisa = {1'b0, frac_field};
    end else if (exp_ones) begin
      flags = FLAG_INF;
      exp   = '1;
    end else begin
      flags   = FLAG_NORMAL;
      mantisa = {1'b1, frac_field};
      exp     = exp_field;
    end
  end

endmodule

// File: rtl/input_wrapper.sv
// -----------------------------------------------------------------------------
// input_wrapper
// Two-stage elastic front end of the sqrt core. S1 captures the raw operand,
// the classifier decodes it, and S2 registers the classified result that is
// presented downstream. Each stage loads when it is empty or being drained in
// the same cycle, so a full pipeline shifts without bubbles and a stalled
// output holds its value.
//
// Ports
//   clk          in   1                 clock
//   rst          in   1                 synchronous active-high reset
//   in_valid     in   1                 in_data valid
//   in_ready     out  1                 operand accepted this cycle
//   in_data      in   M_SIZE+EXP_SIZE   operand, {sign, exponent, fraction}
//   out_valid    out  1                 out_* valid
//   out_ready    in   1                 downstream accepts
//   out_mantisa  out  M_SIZE            {hidden bit, fraction}
//   out_exp      out  EXP_SIZE          biased exponent
//   out_flags    out  3                 operand class code
// -----------------------------------------------------------------------------
module input_wrapper
  import input_wrapper_pkg::*;
#(
  parameter int M_SIZE   = DEF_M_SIZE,
  parameter int EXP_SIZE = DEF_EXP_SIZE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [M_SIZE+EXP_SIZE-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M_SIZE-1:0]          out_mantisa,
  output logic [EXP_SIZE-1:0]        out_exp,
  output logic [2:0]                 out_flags
);

  localparam int W = M_SIZE + EXP_SIZE;

  // Stage 1: raw operand
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_data_q,  s1_data_d;

  // Stage 2: classified result
  logic                out_valid_q,   out_valid_d;
  logic [M_SIZE-1:0]   out_mantisa_q, out_mantisa_d;
  logic [EXP_SIZE-1:0] out_exp_q,     out_exp_d;
  logic [2:0]          out_flags_q,   out_flags_d;

  // Classifier results for the operand sitting in S1
  logic [M_SIZE-1:0]   cls_mantisa;
  logic [EXP_SIZE-1:0] cls_exp;
  logic [2:0]          cls_flags;

  logic s2_load;
  logic in_fire;

  input_classifier #(
    .M_SIZE   (M_SIZE),
    .EXP_SIZE (EXP_SIZE)
  ) u_classifier (
    .data    (s1_data_q),
    .mantisa (cls_mantisa),
    .exp     (cls_exp),
    .flags   (cls_flags)
  );

  always_comb begin
    // S2 takes S1's operand when S2 is empty or its content leaves this cycle.
    s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    // S1 can accept when empty or when it is moving into S2. This depends only
    // on registered state and out_ready, never on in_valid.
    in_ready = !rst && (!s1_valid_q || s2_load);
    in_fire  = in_valid && in_ready;

    s1_valid_d    = in_fire || (s1_valid_q && !s2_load);
    s1_data_d     = s1_data_q;
    out_valid_d   = s2_load || (out_valid_q && !out_ready);
    out_mantisa_d = out_mantisa_q;
    out_exp_d     = out_exp_q;
    out_flags_d   = out_flags_q;

    if (in_fire) begin
      s1_data_d = in_data;
    end
    if (s2_load) begin
      out_mantisa_d = cls_mantisa;
      out_exp_d     = cls_exp;
      out_flags_d   = cls_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      out_valid_q   <= 1'b0;
      out_mantisa_q <= '0;
      out_exp_q     <= '0;
      out_flags_q   <= FLAG_ZERO;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      out_valid_q   <= out_valid_d;
      out_mantisa_q <= out_mantisa_d;
      out_exp_q     <= out_exp_d;
      out_flags_q   <= out_flags_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_mantisa = out_mantisa_q;
  assign out_exp     = out_exp_q;
  assign out_flags   = out_flags_q;

endmodule
